// File: rtl/phase_timer.sv
// phase_timer: one-second-resolution countdown for the traffic light
// controller. A load strobe captures a 6-bit phase duration, which an
// internal prescaler counts down once every TICK_DIV enabled cycles. When
// the count reaches zero, a one-cycle expired pulse is issued.
// Optional feature: define PHASE_TIMER_BCD_EN to get a registered
// binary-to-BCD conversion of the remaining time on bcd_tens/bcd_ones.
// Without the macro, both digit outputs are tied to zero.
module phase_timer #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [5:0] load_value,
   input  logic       enable,
   output logic [5:0] count,
   output logic       busy,
   output logic       sec_tick,
   output logic       expired,
   output logic [3:0] bcd_tens,
   output logic [3:0] bcd_ones
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [5:0]    count_q, count_d;
   logic          tick_q, tick_d;
   logic          expired_q, expired_d;

   // State, prescaler, count and pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         count_q   <= '0;
         tick_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         count_q   <= count_d;
         tick_q    <= tick_d;
         expired_q <= expired_d;
      end
   end

   // Next-state logic: load takes priority over a same-cycle tick
   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      count_d   = count_q;
      tick_d    = 1'b0;
      expired_d = 1'b0;
      if (load) begin
         count_d = load_value;
         presc_d = '0;
         if (load_value == 6'd0) begin
            state_d   = IDLE;
            expired_d = 1'b1;
         end else begin
            state_d = RUN;
         end
      end else if (state_q == RUN && enable) begin
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (count_q != 6'd0) begin
               count_d = count_q - 6'd1;
            end
            if (count_q <= 6'd1) begin
               state_d   = IDLE;
               expired_d = 1'b1;
            end
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   assign count    = count_q;
   assign busy     = (state_q == RUN);
   assign sec_tick = tick_q;
   assign expired  = expired_q;

`ifdef PHASE_TIMER_BCD_EN
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic [5:0] tens_full;
   logic [5:0] ones_full;

   // Binary-to-BCD split of the registered count (0-63 -> tens 0-6, ones 0-9)
   always_comb begin
      tens_full = count_q / 6'd10;
      ones_full = count_q - (tens_full * 6'd10);
      tens_d    = tens_full[3:0];
      ones_d    = ones_full[3:0];
   end

   // Digit registers, one cycle behind count
   always_ff @(posedge clk) begin
      if (rst) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign bcd_tens = tens_q;
   assign bcd_ones = ones_q;
`else
   assign bcd_tens = '0;
   assign bcd_ones = '0;
`endif

endmodule

// File: tb/tb_phase_timer.sv
// Directed testbench for phase_timer with TICK_DIV = 4.
module tb_phase_timer;

   logic       clk;
   logic       rst;
   logic       load;
   logic [5:0] load_value;
   logic       enable;
   logic [5:0] count;
   logic       busy;
   logic       sec_tick;
   logic       expired;
   logic [3:0] bcd_tens;
   logic [3:0] bcd_ones;

   int checks   = 0;
   int failures = 0;

   phase_timer #(.TICK_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_value (load_value),
      .enable     (enable),
      .count      (count),
      .busy       (busy),
      .sec_tick   (sec_tick),
      .expired    (expired),
      .bcd_tens   (bcd_tens),
      .bcd_ones   (bcd_ones)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      load       = 1'b0;
      load_value = '0;
      enable     = 1'b1;
      step();
      step();
      rst = 1'b0;
      check_eq("rst_count", count, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_tick", sec_tick, 0);
      check_eq("rst_exp", expired, 0);
      check_eq("rst_tens", bcd_tens, 0);
      check_eq("rst_ones", bcd_ones, 0);

      // Load 3: decrements every 4 cycles, expired 12 cycles after load edge
      load = 1'b1; load_value = 6'd3;
      step();
      load = 1'b0;
      check_eq("t1_load_count", count, 3);
      check_eq("t1_load_busy", busy, 1);
      for (int k = 1; k <= 12; k++) begin
         step();
         check_eq("t1_count", count, 32'(3 - k / 4));
         check_eq("t1_tick", sec_tick, 32'(k % 4 == 0));
         check_eq("t1_exp", expired, 32'(k == 12));
         check_eq("t1_busy", busy, 32'(k < 12));
      end
      step();
      check_eq("t1_exp_after", expired, 0);
      check_eq("t1_count_after", count, 0);

      // Load 0: immediate expire, stay idle
      load = 1'b1; load_value = 6'd0;
      step();
      load = 1'b0;
      check_eq("t2_count", count, 0);
      check_eq("t2_exp", expired, 1);
      check_eq("t2_busy", busy, 0);
      check_eq("t2_tick", sec_tick, 0);
      step();
      check_eq("t2_exp_after", expired, 0);
      check_eq("t2_busy_after", busy, 0);

      // Load 5, freeze 10 cycles after second tick
      load = 1'b1; load_value = 6'd5;
      step();
      load = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         check_eq("t3_count_a", count, 32'(5 - k / 4));
         check_eq("t3_tick_a", sec_tick, 32'(k % 4 == 0));
      end
      enable = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         check_eq("t3_hold_count", count, 3);
         check_eq("t3_hold_tick", sec_tick, 0);
         check_eq("t3_hold_busy", busy, 1);
      end
      enable = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         check_eq("t3_count_b", count, 32'(3 - k / 4));
         check_eq("t3_tick_b", sec_tick, 32'(k % 4 == 0));
         check_eq("t3_exp_b", expired, 32'(k == 12));
      end

      // Reload 30 on the tick edge that would take count from 2 to 1
      load = 1'b1; load_value = 6'd3;
      step();
      load = 1'b0;
      for (int k = 1; k <= 7; k++) step();
      check_eq("t4_pre_count", count, 2);
      load = 1'b1; load_value = 6'd30;
      step();
      load = 1'b0;
      check_eq("t4_count", count, 30);
      check_eq("t4_tick", sec_tick, 0);
      check_eq("t4_exp", expired, 0);
      check_eq("t4_busy", busy, 1);
      for (int k = 1; k <= 4; k++) begin
         step();
         check_eq("t4_next_count", count, 32'(k == 4 ? 29 : 30));
         check_eq("t4_next_tick", sec_tick, 32'(k == 4));
      end

      // Reset mid-countdown at count 4
      load = 1'b1; load_value = 6'd4;
      step();
      load = 1'b0;
      step();
      check_eq("t5_pre_count", count, 4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("t5_count", count, 0);
      check_eq("t5_busy", busy, 0);
      check_eq("t5_tick", sec_tick, 0);
      check_eq("t5_exp", expired, 0);
      for (int k = 1; k <= 20; k++) begin
         step();
         check_eq("t5_no_exp", expired, 0);
         check_eq("t5_idle", busy, 0);
         check_eq("t5_hold", count, 0);
      end

      // BCD digits of 47, one cycle after count shows it
      load = 1'b1; load_value = 6'd47;
      step();
      load = 1'b0;
      check_eq("t6_count", count, 47);
      step();
`ifdef PHASE_TIMER_BCD_EN
      check_eq("t6_tens", bcd_tens, 4);
      check_eq("t6_ones", bcd_ones, 7);
`else
      check_eq("t6_tens", bcd_tens, 0);
      check_eq("t6_ones", bcd_ones, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/phase_timer.md
# phase_timer

Countdown timer for the traffic light controller; it sits directly downstream of the green/yellow time selector. It loads the selected 6-bit phase duration (seconds) on a load strobe and counts it down once per second using an internal clock prescaler. It reports the remaining time and a one-cycle `expired` pulse that tells the light-sequencing FSM to advance to the next phase.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per one-second tick (≥1); prescaler width is `$clog2(TICK_DIV)`, minimum 1 bit.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `load`  input  1  single-cycle strobe; capture `load_value` and (re)start the countdown.
- `load_value`  input  6  phase duration in seconds from the time selector (0–63).
- `enable`  input  1  high = prescaler and countdown advance; low = freeze (hold all state).
- `count`  output  6  remaining seconds.
- `busy`  output  1  countdown in progress (RUN state).
- `sec_tick`  output  1  one-cycle pulse each time the prescaler wraps while in RUN.
- `expired`  output  1  one-cycle pulse when the countdown reaches 0.
- `bcd_tens`  output  4  tens digit of `count` (see Configuration).
- `bcd_ones`  output  4  ones digit of `count` (see Configuration).

## Operation
- FSM states: IDLE, RUN. Reset state is IDLE.
- IDLE, `load`=1, `load_value`>0: `count`←`load_value`, prescaler←0, go to RUN.
- IDLE, `load`=1, `load_value`=0: `count`←0, pulse `expired`, stay in IDLE. A zero-length phase expires immediately.
- IDLE, no `load`: hold `count`; prescaler stays at 0.
- RUN: the prescaler increments on each cycle with `enable`=1. At `TICK_DIV-1` it wraps to 0 and generates the tick; `count` decrements by 1 and `sec_tick` pulses.
- RUN, tick with `count`=1: `count`←0, pulse `expired`, go to IDLE.
- RUN, `load`=1: restart exactly as from IDLE, including the zero case, which goes to IDLE with `expired`. `load` has priority over a same-cycle tick: no decrement, no `sec_tick`, no `expired` from the old countdown.
- `enable`=0: prescaler, `count` and state hold. `load` is still accepted regardless of `enable`.
- `count` never wraps below 0. No decrement occurs in IDLE.
- `busy` = (state == RUN).
- `rst` mid-countdown: abandon the countdown and return to reset values next edge. No `expired` is generated.

## Timing
- Reset values: `count`=0, `busy`=0, `sec_tick`=0, `expired`=0, `bcd_tens`=0, `bcd_ones`=0, prescaler=0, state IDLE.
- All outputs are registered.
- `load` sampled at edge N: `count`=`load_value` and `busy`=1 are visible after edge N.
- First tick occurs at the edge ending the `TICK_DIV`-th enabled cycle after the load edge. Each subsequent tick follows `TICK_DIV` enabled cycles later.
- `sec_tick` and the `count` decrement appear after the same edge.
- `expired` is high for exactly the one cycle in which `count` first reads 0; `busy` is 0 in that cycle.
- Load of value V with `enable` held high: `expired` asserts V×`TICK_DIV` cycles after the load edge.
- `TICK_DIV`=1: tick on every enabled RUN cycle.

## Configuration
- `PHASE_TIMER_BCD_EN` defined: a registered binary-to-BCD converter drives `bcd_tens`/`bcd_ones` from `count`. Tens range is 0–6, ones range is 0–9. Digits lag `count` by one cycle, for the seven-segment remaining-time display.
- Not defined: no converter logic. `bcd_tens` and `bcd_ones` are tied to 0; the port list is unchanged.

## Test plan
- `TICK_DIV`=4, `enable`=1, load 3 → `count` 3,2,1,0 with decrements 4 cycles apart; `sec_tick` on each decrement; `expired` one cycle, 12 cycles after the load edge; `busy` drops with `expired`.
- Load 0 → next cycle `count`=0, `expired`=1 for one cycle, `busy` stays 0, no `sec_tick`.
- Load 5, drop `enable` for 10 cycles after second tick → `count` holds 3 and the prescaler holds; completion is delayed by exactly 10 cycles.
- During RUN at `count`=2, assert `load`=30 on the tick cycle → `count`=30, no decrement, no `expired`; the next tick comes 4 cycles later.
- Assert `rst` at `count`=4 in RUN → next cycle all outputs 0, IDLE, and no `expired` for the rest of the test.
- With `PHASE_TIMER_BCD_EN`, load 47 → one cycle later `bcd_tens`=4, `bcd_ones`=7. Without the macro, both read 0.
